// File: rtl/sd_dat_block_rx.sv
// SD card DAT[3:0] read-block receiver: start bit, payload, per-line CRC16, end bit.
// Build option SD_DAT_RX_1BIT_EN adds a bus_1bit input, latched at arm, that selects 1-bit bus mode.
//
// state  | meaning
// S_IDLE | waiting for arm
// S_WAIT | counting samples until a start bit or timeout
// S_DATA | deserialising payload into bytes, updating per-line CRC16
// S_CRC  | shifting in the 16 received CRC bits on each line
// S_END  | end-bit sample: compare CRCs, pulse done
module sd_dat_block_rx #(
    parameter int BLOCK_BYTES     = 512,
    parameter int TIMEOUT_SAMPLES = 65535,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [3:0] dat_in,
    input  logic       arm,
    input  logic       abort,
`ifdef SD_DAT_RX_1BIT_EN
    input  logic       bus_1bit,
`endif
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] crc_err,
    output logic       timeout,
    output logic       overflow
);

`ifdef SD_DAT_RX_1BIT_EN
    localparam int SPB_MAX = 8;
`else
    localparam int SPB_MAX = 2;
`endif
    localparam int DCW = $clog2(BLOCK_BYTES * SPB_MAX) + 1;
    localparam int TCW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = FAW + 1;

    localparam logic [DCW-1:0] LAST_4BIT = DCW'(BLOCK_BYTES * 2 - 1);
    localparam logic [TCW-1:0] T_LIMIT   = TCW'(TIMEOUT_SAMPLES);
    localparam logic [FCW-1:0] F_FULL    = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_CRC,
        S_END
    } state_t;

    state_t                     state_q, state_d;
    logic [TCW-1:0]             tcnt_q, tcnt_d;
    logic [DCW-1:0]             dcnt_q, dcnt_d;
    logic [3:0]                 ccnt_q, ccnt_d;
    logic [7:0]                 shift_q, shift_d;
    logic [3:0][15:0]           crc_q, crc_d;
    logic [3:0][15:0]           rx_crc_q, rx_crc_d;
    logic [3:0]                 crc_err_q, crc_err_d;
    logic                       timeout_q, timeout_d;
    logic                       overflow_q, overflow_d;
    logic                       done_q, done_d;

    logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [FAW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]             fcnt_q, fcnt_d;

    logic                       one_bit;
    logic [DCW-1:0]             data_last;
    logic                       byte_done;
    logic                       start_bit;
    logic [7:0]                 shift_next;
    logic [3:0]                 line_mask;
    logic                       push;
    logic                       do_push;
    logic                       pop;
    logic                       full;

`ifdef SD_DAT_RX_1BIT_EN
    localparam logic [DCW-1:0] LAST_1BIT = DCW'(BLOCK_BYTES * 8 - 1);

    logic mode_q, mode_d;

    assign one_bit   = mode_q;
    assign data_last = one_bit ? LAST_1BIT : LAST_4BIT;
    assign byte_done = one_bit ? (dcnt_q[2:0] == 3'b111) : dcnt_q[0];
`else
    assign one_bit   = 1'b0;
    assign data_last = LAST_4BIT;
    assign byte_done = dcnt_q[0];
`endif

    assign start_bit  = one_bit ? ~dat_in[0] : (dat_in == 4'b0000);
    assign shift_next = one_bit ? {shift_q[6:0], dat_in[0]} : {shift_q[3:0], dat_in};
    assign line_mask  = one_bit ? 4'b0001 : 4'b1111;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        dcnt_d     = dcnt_q;
        ccnt_d     = ccnt_q;
        shift_d    = shift_q;
        crc_d      = crc_q;
        rx_crc_d   = rx_crc_q;
        crc_err_d  = crc_err_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        push       = 1'b0;
`ifdef SD_DAT_RX_1BIT_EN
        mode_d     = mode_q;
`endif

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        crc_err_d  = 4'b0000;
                        timeout_d  = 1'b0;
                        overflow_d = 1'b0;
                        tcnt_d     = '0;
                        state_d    = S_WAIT;
`ifdef SD_DAT_RX_1BIT_EN
                        mode_d     = bus_1bit;
`endif
                    end
                end
                S_WAIT: begin
                    if (sample_en) begin
                        if (start_bit) begin
                            crc_d    = '0;
                            rx_crc_d = '0;
                            dcnt_d   = '0;
                            ccnt_d   = '0;
                            shift_d  = '0;
                            state_d  = S_DATA;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                            if (tcnt_d == T_LIMIT) begin
                                timeout_d = 1'b1;
                                done_d    = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (sample_en) begin
                        // Unused lines in 1-bit mode still run their CRC; the result is masked at the end.
                        for (int i = 0; i < 4; i++) begin
                            crc_d[i] = crc16_step(crc_q[i], dat_in[i]);
                        end
                        shift_d = shift_next;
                        push    = byte_done;
                        if (dcnt_q == data_last) begin
                            state_d = S_CRC;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    if (sample_en) begin
                        for (int i = 0; i < 4; i++) begin
                            rx_crc_d[i] = {rx_crc_q[i][14:0], dat_in[i]};
                        end
                        ccnt_d = ccnt_q + 1'b1;
                        if (ccnt_q == 4'd15) begin
                            state_d = S_END;
                        end
                    end
                end
                S_END: begin
                    if (sample_en) begin
                        for (int i = 0; i < 4; i++) begin
                            crc_err_d[i] = line_mask[i] & (rx_crc_q[i] != crc_q[i]);
                        end
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pop      = (fcnt_q != '0) && out_ready;
        full     = (fcnt_q == F_FULL);
        do_push  = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;

        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end else begin
            // A full FIFO that is popped this cycle can still take the new byte.
            if (push && full && !pop) begin
                overflow_d = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = shift_next;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            fcnt_d = fcnt_q + FCW'(do_push) - FCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            ccnt_q     <= '0;
            shift_q    <= '0;
            crc_q      <= '0;
            rx_crc_q   <= '0;
            crc_err_q  <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
`ifdef SD_DAT_RX_1BIT_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            ccnt_q     <= ccnt_d;
            shift_q    <= shift_d;
            crc_q      <= crc_d;
            rx_crc_q   <= rx_crc_d;
            crc_err_q  <= crc_err_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
`ifdef SD_DAT_RX_1BIT_EN
            mode_q     <= mode_d;
`endif
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (fcnt_q != '0);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign crc_err   = crc_err_q;
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Randomised bench for sd_dat_block_rx: drives SD read blocks and compares against a
// byte-array model whose CRC16 is computed by polynomial long division.
module tb_sd_dat_block_rx;
    localparam int BB = 512;
    localparam int TO = 100;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [3:0] dat_in;
    logic       arm;
    logic       abort;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] crc_err;
    logic       timeout;
    logic       overflow;
`ifdef SD_DAT_RX_1BIT_EN
    logic       bus_1bit = 1'b0;
`endif

    int         n_chk = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         rdy_mode = 1;
    logic [7:0] got[$];
    logic [7:0] blk[BB];

    sd_dat_block_rx #(
        .BLOCK_BYTES(BB),
        .TIMEOUT_SAMPLES(TO),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_en(sample_en),
        .dat_in(dat_in),
        .arm(arm),
        .abort(abort),
`ifdef SD_DAT_RX_1BIT_EN
        .bus_1bit(bus_1bit),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .crc_err(crc_err),
        .timeout(timeout),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Handshakes and done pulses are observed mid-cycle, between driving and the next edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = out_ready ? 1'($urandom) : 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [3:0] d, input int max_gap);
        int gap;
        gap       = $urandom_range(0, max_gap);
        dat_in    = d;
        sample_en = 1'b1;
        cyc();
        sample_en = 1'b0;
        dat_in    = 4'($urandom);
        for (int g = 0; g < gap; g++) cyc();
    endtask

    task automatic pulse_arm(input bit with_start);
        arm = 1'b1;
        if (with_start) begin
            sample_en = 1'b1;
            dat_in    = 4'h0;
        end
        cyc();
        arm       = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic send_bytes(input int lo, input int hi, input int max_gap);
        for (int k = lo; k < hi; k++) begin
            send_sample(blk[k][7:4], max_gap);
            send_sample(blk[k][3:0], max_gap);
        end
    endtask

    // CRC16 x^16+x^12+x^5+1 of one DAT line as the remainder of (message * x^16) mod G.
    function automatic logic [15:0] line_crc(input int ln);
        logic [16:0] r;
        logic        b;
        r = '0;
        for (int k = 0; k < BB; k++) begin
            for (int h = 1; h >= 0; h--) begin
                b = blk[k][h*4+ln];
                r = {r[15:0], b};
                if (r[16]) r = r ^ 17'h11021;
            end
        end
        for (int z = 0; z < 16; z++) begin
            r = {r[15:0], 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic send_crc_end(input logic [3:0] flip, input int max_gap);
        logic [15:0] c[4];
        logic [3:0]  nib;
        for (int i = 0; i < 4; i++) c[i] = line_crc(i);
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) nib[i] = c[i][15-j] ^ (flip[i] && j == 15);
            send_sample(nib, max_gap);
        end
        send_sample(4'hF, max_gap);
    endtask

    task automatic wait_drain(input int n);
        for (int t = 0; t < 4000 && got.size() < n; t++) cyc();
        repeat (4) cyc();
    endtask

    task automatic check_bytes(input string tag, input int n);
        int mis;
        mis = 0;
        chk({tag, "_count"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++) begin
            if (got[k] !== blk[k]) mis++;
        end
        chk({tag, "_bytes"}, mis, 0);
    endtask

    task automatic check_block(input string tag, input logic [3:0] exp_err);
        check_bytes(tag, BB);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_crc_err"}, crc_err, exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        int         bad;
        logic [3:0] flip;

        reset     = 1'b1;
        sample_en = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        dat_in    = 4'h0;
        cyc();

        bad = 0;
        for (int c = 0; c < 100; c++) begin
            dat_in    = 4'($urandom);
            sample_en = 1'($urandom);
            arm       = 1'($urandom);
            abort     = 1'($urandom);
            cyc();
            if ({busy, out_valid, done, crc_err, timeout, overflow} !== 9'b0 || out_data !== 8'h00) bad++;
        end
        chk("reset_hold", bad, 0);
        sample_en = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        reset     = 1'b0;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_flags", {done, crc_err, timeout, overflow}, 0);

        foreach (blk[k]) blk[k] = 8'h00;
        got.delete();
        done_cnt = 0;
        pulse_arm(0);
        send_sample(4'h0, 2);
        send_bytes(0, BB, 2);
        send_crc_end(4'b0000, 2);
        wait_drain(BB);
        check_block("zero", 4'b0000);

        got.delete();
        done_cnt = 0;
        pulse_arm(0);
        send_sample(4'h0, 2);
        send_bytes(0, BB, 2);
        send_crc_end(4'b0100, 2);
        wait_drain(BB);
        check_block("flip2", 4'b0100);

        for (int r = 0; r < 3; r++) begin
            foreach (blk[k]) blk[k] = 8'($urandom);
            flip = 4'($urandom);
            got.delete();
            done_cnt = 0;
            rdy_mode = 2;
            pulse_arm(1);
            repeat ($urandom_range(0, 5)) send_sample(4'($urandom_range(1, 15)), 2);
            send_sample(4'h0, 2);
            send_bytes(0, BB / 2, 2);
            arm = 1'b1;
            cyc();
            arm = 1'b0;
            send_bytes(BB / 2, BB, 2);
            send_crc_end(flip, 2);
            wait_drain(BB);
            check_block($sformatf("rand%0d", r), flip);
        end
        rdy_mode = 1;

        got.delete();
        done_cnt = 0;
        pulse_arm(0);
        for (int s = 0; s < TO - 1; s++) send_sample(4'($urandom_range(1, 15)), 1);
        chk("to_busy_before", busy, 1);
        chk("to_flag_before", timeout, 0);
        send_sample(4'hF, 0);
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        repeat (3) cyc();
        chk("to_done", done_cnt, 1);
        chk("to_nobytes", got.size(), 0);
        chk("to_sticky", timeout, 1);

        foreach (blk[k]) blk[k] = 8'(k);
        rdy_mode = 0;
        cyc();
        got.delete();
        done_cnt = 0;
        pulse_arm(0);
        chk("arm_clears_to", timeout, 0);
        send_sample(4'h0, 1);
        send_sample(blk[0][7:4], 0);
        chk("fifo_lat_pre", out_valid, 0);
        send_sample(blk[0][3:0], 0);
        chk("fifo_lat", out_valid, 1);
        chk("fifo_head", out_data, 8'h00);
        send_bytes(1, 4, 1);
        chk("ovf_at4", overflow, 0);
        send_bytes(4, 5, 1);
        chk("ovf_at5", overflow, 1);
        send_bytes(5, BB, 1);
        send_crc_end(4'b0000, 1);
        repeat (3) cyc();
        chk("ovf_done", done_cnt, 1);
        chk("ovf_crc", crc_err, 0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_held", got.size(), 0);
        rdy_mode = 1;
        wait_drain(4);
        check_bytes("ovf_drain", 4);
        chk("ovf_empty", out_valid, 0);

        foreach (blk[k]) blk[k] = 8'($urandom);
        rdy_mode = 0;
        cyc();
        got.delete();
        done_cnt = 0;
        pulse_arm(0);
        chk("arm_clears_ovf", overflow, 0);
        send_sample(4'h0, 1);
        send_bytes(0, 10, 1);
        abort = 1'b1;
        arm   = 1'b1;
        cyc();
        abort = 1'b0;
        arm   = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        rdy_mode = 1;
        repeat (6) cyc();
        chk("abort_flushed", got.size(), 0);
        chk("abort_nodone", done_cnt, 0);

        foreach (blk[k]) blk[k] = 8'($urandom);
        got.delete();
        done_cnt = 0;
        rdy_mode = 2;
        pulse_arm(0);
        send_sample(4'h0, 2);
        send_bytes(0, BB, 2);
        send_crc_end(4'b0000, 2);
        wait_drain(BB);
        check_block("after_abort", 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
